// File: rtl/alu_uart_sequencer.sv
// Byte-stream front end for the ALU: collects operand A, operand B and the operator
// from a UART receiver, then hands the registered ALU result to a UART transmitter.
module alu_uart_sequencer #(
  parameter int NB_BYTE     = 8,
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NB_BYTE-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  input  logic [NB_DATA-1:0]     i_resultado,
  input  logic                   i_tx_done,
  output logic [NB_DATA-1:0]     o_dato_a,
  output logic [NB_DATA-1:0]     o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    RESULT,
    WAIT_TX
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_busy_next;
  logic                   w_in_busy;
  logic [NB_DATA-1:0]     r_dato_a;
  logic [NB_DATA-1:0]     r_dato_b;
  logic [NB_OPERADOR-1:0] r_operador;
  logic [NB_BYTE-1:0]     r_tx_data;
  logic                   r_tx_start;
  logic                   r_busy;
  logic                   r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_A;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_A:  if (i_rx_done) w_next = WAIT_B;
      WAIT_B:  if (i_rx_done) w_next = WAIT_OP;
      WAIT_OP: if (i_rx_done) w_next = RESULT;
      RESULT:  w_next = WAIT_TX;
      WAIT_TX: if (i_tx_done) w_next = WAIT_A;
      default: w_next = WAIT_A;
    endcase
  end

  assign w_in_busy   = (r_state == RESULT) || (r_state == WAIT_TX);
  assign w_busy_next = (w_next == RESULT) || (w_next == WAIT_TX);

  // Busy and tx_start are registered copies of the state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dato_a   <= '0;
      r_dato_b   <= '0;
      r_operador <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tx_start <= (r_state == RESULT);
      r_busy     <= w_busy_next;
      if (i_rx_done && w_in_busy) r_overrun <= 1'b1;
      case (r_state)
        WAIT_A:  if (i_rx_done) r_dato_a   <= i_rx_data[NB_DATA-1:0];
        WAIT_B:  if (i_rx_done) r_dato_b   <= i_rx_data[NB_DATA-1:0];
        WAIT_OP: if (i_rx_done) r_operador <= i_rx_data[NB_OPERADOR-1:0];
        RESULT:  r_tx_data <= NB_BYTE'(i_resultado);
        default: ;
      endcase
    end
  end

  assign o_dato_a   = r_dato_a;
  assign o_dato_b   = r_dato_b;
  assign o_operador = r_operador;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed self-checking bench for alu_uart_sequencer: default widths plus a
// second instance with NB_DATA=6 for truncation.
module tb_alu_uart_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data, tx_data;
  logic       rx_done, tx_done, tx_start, busy, overrun;
  logic [7:0] dato_a, dato_b, resultado;
  logic [5:0] operador;

  logic [7:0] t_rx_data, t_tx_data;
  logic       t_rx_done, t_tx_done, t_tx_start, t_busy, t_overrun;
  logic [5:0] t_dato_a, t_dato_b, t_resultado, t_operador;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  // Small ALU model: add/sub/and/or selected by the operator code
  always_comb begin
    case (operador)
      6'h20:   resultado = dato_a + dato_b;
      6'h22:   resultado = dato_a - dato_b;
      6'h24:   resultado = dato_a & dato_b;
      default: resultado = dato_a | dato_b;
    endcase
  end
  assign t_resultado = t_dato_a | t_dato_b;

  alu_uart_sequencer #(.NB_BYTE(8), .NB_DATA(8), .NB_OPERADOR(6)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_resultado(resultado), .i_tx_done(tx_done), .o_dato_a(dato_a),
    .o_dato_b(dato_b), .o_operador(operador), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_busy(busy), .o_overrun(overrun)
  );

  alu_uart_sequencer #(.NB_BYTE(8), .NB_DATA(6), .NB_OPERADOR(6)) dut_t (
    .clk(clk), .rst_n(rst_n), .i_rx_data(t_rx_data), .i_rx_done(t_rx_done),
    .i_resultado(t_resultado), .i_tx_done(t_tx_done), .o_dato_a(t_dato_a),
    .o_dato_b(t_dato_b), .o_operador(t_operador), .o_tx_data(t_tx_data),
    .o_tx_start(t_tx_start), .o_busy(t_busy), .o_overrun(t_overrun)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_t(input logic [7:0] b);
    t_rx_data = b;
    t_rx_done = 1'b1;
    @(negedge clk);
    t_rx_done = 1'b0;
  endtask

  task automatic tx_finish();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_after_txdone", busy, 1'b0);
  endtask

  // Called right after the operator byte: RESULT now, pulse next cycle, gone after.
  task automatic expect_pulse(input string tag, input logic [7:0] exp);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_start_early"}, tx_start, 1'b0);
    @(negedge clk);
    check({tag, "_start"}, tx_start, 1'b1);
    check({tag, "_data"}, tx_data, exp);
    @(negedge clk);
    check({tag, "_start_end"}, tx_start, 1'b0);
    check({tag, "_data_hold"}, tx_data, exp);
    check({tag, "_busy_wait"}, busy, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, dato_a, 8'h00);
    check({tag, "_b"}, dato_b, 8'h00);
    check({tag, "_op"}, operador, 6'h00);
    check({tag, "_txd"}, tx_data, 8'h00);
    check({tag, "_start"}, tx_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
    t_rx_data = '0; t_rx_done = 1'b0; t_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_start", tx_start, 1'b0);

    // Basic transaction
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    check("basic_a", dato_a, 8'h05);
    check("basic_b", dato_b, 8'h03);
    check("basic_op", operador, 6'h20);
    expect_pulse("basic", 8'h08);

    // Overrun while waiting on the transmitter
    send_byte(8'h7A);
    check("ovr_set", overrun, 1'b1);
    check("ovr_a_kept", dato_a, 8'h05);
    tx_finish();
    send_byte(8'h0A);
    check("ovr_next_a", dato_a, 8'h0A);
    check("ovr_sticky", overrun, 1'b1);
    send_byte(8'h04); send_byte(8'h22);
    expect_pulse("sub", 8'h06);

    // Back-to-back: rx strobe on the cycle right after tx_done
    tx_finish();
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h25);
    expect_pulse("b2b1", 8'hFF);
    tx_finish();
    send_byte(8'h33); send_byte(8'h0F); send_byte(8'h24);
    expect_pulse("b2b2", 8'h03);

    // rx and tx done together in WAIT_TX: byte dropped, return to WAIT_A
    rx_data = 8'h55; rx_done = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; tx_done = 1'b0;
    check("both_busy", busy, 1'b0);
    check("both_a_kept", dato_a, 8'h33);
    send_byte(8'h11);
    check("both_next_a", dato_a, 8'h11);
    send_byte(8'h22); send_byte(8'h20);
    @(negedge clk);
    check("midtx_start_hi", tx_start, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midtx_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after A and B, then a fresh sequence; stray tx_done in WAIT_B ignored
    send_byte(8'h44); send_byte(8'h55);
    check("mid_b", dato_b, 8'h55);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h01);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("stray_txdone_busy", busy, 1'b0);
    send_byte(8'h02);
    check("stray_b", dato_b, 8'h02);
    send_byte(8'h20);
    expect_pulse("after_reset", 8'h03);
    tx_finish();

    // Truncation with NB_DATA=6
    send_t(8'hFF); send_t(8'hC1); send_t(8'hE2);
    check("trunc_a", t_dato_a, 6'h3F);
    check("trunc_b", t_dato_b, 6'h01);
    check("trunc_op", t_operador, 6'h22);
    @(negedge clk);
    check("trunc_start", t_tx_start, 1'b1);
    check("trunc_data", t_tx_data, 8'h3F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Byte-stream front end for the ALU: accepts operand A, operand B and the operator as three consecutive bytes from a serial receiver, drives them to the combinational ALU, then hands the registered result to a serial transmitter with a start/done handshake. It replaces the switch/button loading path when the ALU is driven remotely, sitting between the UART RX/TX pair and the ALU instance.

## Interface
- NB_BYTE, 8, width of rx/tx byte bus
- NB_DATA, 8, ALU operand/result width (NB_DATA <= NB_BYTE)
- NB_OPERADOR, 6, ALU operator width (NB_OPERADOR <= NB_BYTE)

- clk  in  1  single system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_BYTE  received byte, valid while i_rx_done high
- i_rx_done  in  1  one-cycle strobe: new byte on i_rx_data
- i_resultado  in  NB_DATA  combinational ALU result
- i_tx_done  in  1  one-cycle strobe: transmitter finished current byte
- o_dato_a  out  NB_DATA  operand A to ALU (registered)
- o_dato_b  out  NB_DATA  operand B to ALU (registered)
- o_operador  out  NB_OPERADOR  operator to ALU (registered)
- o_tx_data  out  NB_BYTE  result byte to transmitter (registered)
- o_tx_start  out  1  one-cycle strobe: start transmitting o_tx_data
- o_busy  out  1  high in RESULT and WAIT_TX
- o_overrun  out  1  sticky: byte received while busy; cleared only by reset

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, RESULT, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on i_rx_done, o_dato_a <= i_rx_data[NB_DATA-1:0], go WAIT_B.
- WAIT_B: on i_rx_done, o_dato_b <= i_rx_data[NB_DATA-1:0], go WAIT_OP.
- WAIT_OP: on i_rx_done, o_operador <= i_rx_data[NB_OPERADOR-1:0], go RESULT.
- RESULT (exactly one cycle, ALU settle): o_tx_data <= i_resultado zero-extended to NB_BYTE; o_tx_start <= 1; go WAIT_TX.
- WAIT_TX: o_tx_start 0; on i_tx_done go WAIT_A.
- Upper byte bits beyond NB_DATA / NB_OPERADOR discarded.
- o_dato_a, o_dato_b, o_operador hold last values until overwritten; the ALU result stays stable between transactions.
- i_rx_done in RESULT or WAIT_TX: byte dropped, no register or state change, o_overrun <= 1.
- i_tx_done outside WAIT_TX: ignored.
- i_rx_done and i_tx_done same cycle in WAIT_TX: go WAIT_A, rx byte dropped, o_overrun set.
- No timeout: partial sequences (A only, A+B) wait indefinitely.
- Reset (any time, including mid-transmit): all outputs 0, state WAIT_A, o_tx_start deasserted asynchronously.

## Timing
- Byte capture: register updates at the rising edge where i_rx_done is sampled high.
- Operator captured at edge E -> state RESULT during cycle after E -> o_tx_start high for exactly the one cycle following edge E+1, with o_tx_data valid the same cycle and held until next RESULT.
- Latency from operator strobe to o_tx_start: 2 edges.
- o_busy = 1 from edge E to the edge sampling i_tx_done; back-to-back transactions: next A byte accepted the cycle after i_tx_done edge.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset: rst_n low mid-cycle -> all outputs 0 immediately, state WAIT_A; release, no spurious o_tx_start.
- Basic: rx 0x05, 0x03, 0x20; ALU model returns 0x08 -> o_dato_a=0x05, o_dato_b=0x03, o_operador=0x20, o_tx_start single pulse 2 edges after third strobe, o_tx_data=0x08; i_tx_done -> o_busy 0.
- Truncation: NB_DATA=6, rx 0xFF, 0xC1, 0xE2 -> o_dato_a=0x3F, o_dato_b=0x01, o_operador=0x22; result 0x3F -> o_tx_data=0x3F.
- Overrun: rx byte 0x7A during WAIT_TX -> o_overrun=1, o_dato_a unchanged; after i_tx_done next A byte accepted normally; o_overrun stays 1.
- Reset mid-operation: reset after A and B received -> registers 0; new sequence 0x01, 0x02, 0x20 completes with correct pulse.
- Back-to-back: two full transactions with i_tx_done followed next cycle by rx strobe -> two o_tx_start pulses, both results correct.
